// File: rtl/alu_inv_checker.sv
// Built-in self-test for the ALU's conditional B inverter (y = control ? ~b : b).
// Walks every (b, control) pair, compares the returned y and records the result.
module alu_inv_checker #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] b_out,
    output logic         control_out,
    input  logic [N-1:0] y_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_count,
    output logic [N-1:0] first_fail_b,
    output logic         first_fail_control
);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StCheck,
        StDone
    } state_e;

    localparam logic [N:0] KOne = (N + 1)'(1);

    state_e       state_q;
    logic [N:0]   k_q;
    logic         captured_q;

    logic [N-1:0] exp_y;
    logic         mismatch;
    logic         last_vec;
    logic [N:0]   k_inc;
    logic [7:0]   err_next;

    always_comb begin
        exp_y    = k_q[N] ? ~k_q[N-1:0] : k_q[N-1:0];
        mismatch = (y_in != exp_y);
        last_vec = &k_q;
        k_inc    = k_q + KOne;
        // Saturate at 255 so a badly broken inverter never reads as a clean run.
        err_next = err_count;
        if (mismatch && !(&err_count)) begin
            err_next = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= StIdle;
            k_q                <= '0;
            captured_q         <= 1'b0;
            b_out              <= '0;
            control_out        <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            first_fail_b       <= '0;
            first_fail_control <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q            <= StApply;
                        k_q                <= '0;
                        captured_q         <= 1'b0;
                        b_out              <= '0;
                        control_out        <= 1'b0;
                        busy               <= 1'b1;
                        pass               <= 1'b0;
                        err_count          <= '0;
                        first_fail_b       <= '0;
                        first_fail_control <= 1'b0;
                    end
                end

                // Vector already on b_out/control_out; this cycle lets y_in settle.
                StApply: begin
                    state_q <= StCheck;
                end

                StCheck: begin
                    err_count <= err_next;
                    if (mismatch && !captured_q) begin
                        captured_q         <= 1'b1;
                        first_fail_b       <= k_q[N-1:0];
                        first_fail_control <= k_q[N];
                    end
                    if (last_vec) begin
                        state_q     <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= (err_next == 8'd0);
                        b_out       <= '0;
                        control_out <= 1'b0;
                    end else begin
                        state_q     <= StApply;
                        k_q         <= k_inc;
                        b_out       <= k_inc[N-1:0];
                        control_out <= k_inc[N];
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_inv_checker.sv
// Directed bench for alu_inv_checker: good and faulty inverter models at N = 3,
// mid-run reset, held start, and a saturating run at N = 7.
module tb_alu_inv_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start3 = 1'b0;
    logic       start7 = 1'b0;

    logic [2:0] b3, y3, ffb3;
    logic       c3, busy3, done3, pass3, ffc3;
    logic [7:0] err3;

    logic [6:0] b7, y7, ffb7;
    logic       c7, busy7, done7, pass7, ffc7;
    logic [7:0] err7;

    int mode = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // 0: good, 1: y[0] stuck at 0, 2: ignores control, 3: always wrong
    always_comb begin
        case (mode)
            0:       y3 = c3 ? ~b3 : b3;
            1:       y3 = (c3 ? ~b3 : b3) & 3'b110;
            2:       y3 = b3;
            default: y3 = c3 ? b3 : ~b3;
        endcase
    end

    assign y7 = c7 ? b7 : ~b7;

    alu_inv_checker #(.N(3)) dut3 (
        .clk                (clk),
        .reset              (reset),
        .start              (start3),
        .b_out              (b3),
        .control_out        (c3),
        .y_in               (y3),
        .busy               (busy3),
        .done               (done3),
        .pass               (pass3),
        .err_count          (err3),
        .first_fail_b       (ffb3),
        .first_fail_control (ffc3)
    );

    alu_inv_checker #(.N(7)) dut7 (
        .clk                (clk),
        .reset              (reset),
        .start              (start7),
        .b_out              (b7),
        .control_out        (c7),
        .y_in               (y7),
        .busy               (busy7),
        .done               (done7),
        .pass               (pass7),
        .err_count          (err7),
        .first_fail_b       (ffb7),
        .first_fail_control (ffc7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut3 and count cycles from the start edge to done.
    task automatic run3(input string tag, output int cycles);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check({tag, "_busy_after_start"}, busy3, 1);
        cycles = 0;
        while (!done3 && cycles < 2000) begin
            tick();
            cycles++;
        end
        check({tag, "_done_seen"}, done3, 1);
        check({tag, "_busy_in_done"}, busy3, 0);
        tick();
        check({tag, "_done_one_cycle"}, done3, 0);
    endtask

    initial begin
        int cyc;
        int t;
        int d1;
        int d2;
        logic saw_done;

        repeat (3) tick();
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_pass", pass3, 0);
        check("rst_err", err3, 0);
        check("rst_ffb", ffb3, 0);
        check("rst_ffc", ffc3, 0);
        check("rst_b_out", b3, 0);
        check("rst_control_out", c3, 0);
        check("rst_err7", err7, 0);
        reset = 1'b0;
        tick();

        // Good inverter
        mode = 0;
        run3("good", cyc);
        check("good_cycles", cyc, 32);
        check("good_pass", pass3, 1);
        check("good_err", err3, 0);
        check("good_ffb", ffb3, 0);
        check("good_ffc", ffc3, 0);

        // y[0] stuck at 0
        mode = 1;
        run3("stuck0", cyc);
        check("stuck0_cycles", cyc, 32);
        check("stuck0_pass", pass3, 0);
        check("stuck0_err", err3, 8);
        check("stuck0_ffb", ffb3, 3'b001);
        check("stuck0_ffc", ffc3, 0);
        repeat (5) tick();
        check("stuck0_err_hold", err3, 8);
        check("stuck0_ffb_hold", ffb3, 3'b001);

        // Ignores control
        mode = 2;
        run3("nocontrol", cyc);
        check("nocontrol_pass", pass3, 0);
        check("nocontrol_err", err3, 8);
        check("nocontrol_ffb", ffb3, 3'b000);
        check("nocontrol_ffc", ffc3, 1);

        // Reset ten cycles into a failing run
        mode = 3;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (10) tick();
        check("midrst_err_before", err3, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy3, 0);
        check("midrst_err", err3, 0);
        check("midrst_b_out", b3, 0);
        check("midrst_done", done3, 0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done3) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        mode = 0;
        run3("after_rst", cyc);
        check("after_rst_cycles", cyc, 32);
        check("after_rst_pass", pass3, 1);
        check("after_rst_err", err3, 0);

        // start held high on a y = b model
        mode = 2;
        start3 = 1'b1;
        t = 0;
        d1 = -1;
        d2 = -1;
        while (d2 < 0 && t < 200) begin
            tick();
            t++;
            if (done3) begin
                if (d1 < 0) begin
                    d1 = t;
                    check("hold_err_run1", err3, 8);
                end else begin
                    d2 = t;
                    check("hold_err_run2", err3, 8);
                end
            end
        end
        start3 = 1'b0;
        check("hold_first_done", d1, 33);
        check("hold_period", d2 - d1, 34);
        repeat (4) tick();
        check("hold_idle_after", busy3, 0);

        // N = 7, every vector wrong
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        check("n7_busy", busy7, 1);
        cyc = 0;
        while (!done7 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("n7_done_seen", done7, 1);
        check("n7_cycles", cyc, 512);
        check("n7_err_sat", err7, 255);
        check("n7_pass", pass7, 0);
        check("n7_ffb", ffb7, 0);
        check("n7_ffc", ffc7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_inv_checker.md
# alu_inv_checker

Self-test responder for the ALU's conditional B-operand inverter, which computes y = control ? ~b : b. It drives every (b, control) combination into an external inverter instance and samples the returned y. It compares y against the expected value and reports pass/fail, an error count, and the first failing vector. It sits beside the ALU as a built-in checker and is started by a single-cycle start pulse from test logic.

## Interface
- N, 3, operand width of b and y; the vector count is 2^(N+1), so every b value is applied with control = 0 and with control = 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- b_out  out  N  operand driven to the inverter under test.
- control_out  out  1  invert select driven to the inverter under test.
- y_in  in  N  inverter result returned; combinational from b_out/control_out.
- busy  out  1  high in APPLY and CHECK.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 if the last completed run had zero mismatches.
- err_count  out  8  mismatch count, saturating at 255.
- first_fail_b  out  N  b of the first mismatching vector.
- first_fail_control  out  1  control of the first mismatching vector.

## Operation
- Reset values: all outputs 0, state IDLE, vector index k = 0.
- k is an (N+1)-bit counter. Vector k drives b_out = k[N-1:0] and control_out = k[N]. This gives control = 0 for all b first, then control = 1.
- Expected value: exp = k[N] ? ~k[N-1:0] : k[N-1:0]. Compare the full N bits.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE: b_out/control_out = 0. On start = 1:
  - go to APPLY;
  - load k = 0;
  - clear err_count, pass, first_fail_b, first_fail_control and the first-fail-captured flag.
- APPLY: b_out/control_out are registered and hold vector k for this cycle and the next (DUT settle cycle). Always go to CHECK.
- CHECK: sample y_in at the edge leaving CHECK. If y_in != exp:
  - increment err_count, saturating at 255;
  - if no failure has been captured yet, latch first_fail_b = k[N-1:0] and first_fail_control = k[N].
- From CHECK:
  - if k = 2^(N+1)-1, go to DONE;
  - otherwise k <= k+1 and go to APPLY.
- DONE: done = 1 for exactly one cycle. Set pass = 1 if err_count = 0 (including the final vector's result), else 0. Always go to IDLE.
- pass, err_count and the first_fail fields hold after DONE until the next accepted start.
- start in APPLY, CHECK or DONE is ignored. It is not queued.
- Reset mid-run: on the next edge return to IDLE with all outputs at reset values. Partial results are discarded.

## Timing
- Start accepted at edge E0; APPLY for vector k spans cycles E0+2k .. E0+2k+1, with CHECK in the second of those cycles.
- Last compare occurs at edge E0+2^(N+2). done is high during the cycle following that edge. For N = 3, done is high in the cycle starting at E0+32.
- busy rises in the cycle after E0 and falls in the DONE cycle.
- pass updates in the DONE cycle, coincident with done.
- Earliest next accepted start: the IDLE cycle after DONE, giving a run period of 2^(N+2)+2 cycles for back-to-back runs.
- The y_in path is assumed combinational with less than one cycle of settle time.

## Test plan
- Correct inverter model (y = control ? ~b : b), N = 3, one start pulse -> done once, 32 cycles after the start edge; pass = 1; err_count = 0; first_fail fields = 0.
- Inverter with y[0] stuck at 0 -> err_count = 8, pass = 0, first_fail_b = 3'b001, first_fail_control = 0.
- Inverter ignoring control (y = b) -> err_count = 8, pass = 0, first_fail_b = 3'b000, first_fail_control = 1.
- Reset asserted for one cycle 10 cycles into a run -> next cycle busy = 0, err_count = 0, b_out = 0, no done. A subsequent start restarts at k = 0 and completes with pass = 1 on a good model.
- start held high continuously on a y = b model:
  - start is ignored while busy;
  - runs begin 34 cycles apart;
  - err_count reads 8 at each done, never 16, proving it is cleared on each start.
- N = 7, y = ~exp for every vector -> err_count saturates at 255 (not wrapping to 0); pass = 0; first_fail_b = 0, first_fail_control = 0; done 512 cycles after the start edge.
